// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined BIT x BIT multiplier: operand register, 4:2-compressor reduction to two rows, final CPA.
// Optional two's-complement (Baugh-Wooley) mode enabled by macro DADDA_SIGNED_EN (adds the tc input).
module dadda_mult_pipe #(
    parameter int unsigned BIT   = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT-1:0]       a,
    input  logic [BIT-1:0]       b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef DADDA_SIGNED_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*BIT-1:0]     out,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW   = 2 * BIT;
    localparam int unsigned NR   = BIT + 1;   // partial-product rows plus the Baugh-Wooley constant row
    localparam int unsigned RA   = NR + 3;    // row array slack so group indexing never leaves the array
    localparam int unsigned LVLS = 8;         // enough compressor levels for 33 rows

    logic             tc_in;
    logic             adv0, adv1, adv2;
    logic             s0_valid, s1_valid;
    logic [BIT-1:0]   s0_a, s0_b;
    logic [TAG_W-1:0] s0_tag, s1_tag;
    logic             s0_tc;
    logic [PW-1:0]    s1_sum, s1_car;
    logic [PW-1:0]    red_sum, red_car;

`ifdef DADDA_SIGNED_EN
    assign tc_in = tc;
`else
    assign tc_in = 1'b0;
`endif

    // Full-adder row: three rows in, sum row and left-shifted carry row out.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s, c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {s, c};
    endfunction

    // 4:2 compressor row: the first FA's carry feeds the neighbouring column's second FA.
    function automatic logic [2*PW-1:0] comp42(input logic [PW-1:0] x1, input logic [PW-1:0] x2,
                                               input logic [PW-1:0] x3, input logic [PW-1:0] x4);
        logic [2*PW-1:0] fa1;
        fa1 = csa(x1, x2, x3);
        return csa(fa1[2*PW-1:PW], x4, fa1[PW-1:0]);
    endfunction

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign adv0     = !s0_valid || adv1;
    assign in_ready = adv0;

    // Partial products and reduction of all rows down to a sum/carry pair.
    always_comb begin : reduce
        logic [PW-1:0]   rows [RA];
        logic [PW-1:0]   nxt  [RA];
        logic [PW-1:0]   row;
        logic [2*PW-1:0] sc;
        int              n, m;
        for (int k = 0; k < int'(RA); k++) begin
            rows[k] = '0;
            nxt[k]  = '0;
        end
        row = '0;
        sc  = '0;
        m   = 0;
        for (int i = 0; i < int'(BIT); i++) begin
            row = PW'(s0_b & {BIT{s0_a[i]}});
            if (s0_tc) begin
                if (i == int'(BIT) - 1) row[BIT-2:0] = ~row[BIT-2:0];
                else                    row[BIT-1]   = ~row[BIT-1];
            end
            rows[i] = row << i;
        end
        rows[BIT] = s0_tc ? ((PW'(1) << BIT) | (PW'(1) << (PW - 1))) : '0;
        n = int'(NR);
        for (int l = 0; l < int'(LVLS); l++) begin
            if (n > 2) begin
                for (int k = 0; k < int'(RA); k++) nxt[k] = '0;
                m = 0;
                for (int k = 0; k < int'(NR); k += 4) begin
                    if (k + 4 <= n) begin
                        sc        = comp42(rows[k], rows[k+1], rows[k+2], rows[k+3]);
                        nxt[m]    = sc[2*PW-1:PW];
                        nxt[m+1]  = sc[PW-1:0];
                        m         = m + 2;
                    end else if (k + 3 <= n) begin
                        sc        = csa(rows[k], rows[k+1], rows[k+2]);
                        nxt[m]    = sc[2*PW-1:PW];
                        nxt[m+1]  = sc[PW-1:0];
                        m         = m + 2;
                    end else if (k + 2 <= n) begin
                        nxt[m]    = rows[k];
                        nxt[m+1]  = rows[k+1];
                        m         = m + 2;
                    end else if (k + 1 <= n) begin
                        nxt[m]    = rows[k];
                        m         = m + 1;
                    end
                end
                rows = nxt;
                n    = m;
            end
        end
        red_sum = rows[0];
        red_car = rows[1];
    end

    // Stage valids and the output register are the only reset state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
        end else begin
            if (adv0) s0_valid  <= in_valid;
            if (adv1) s1_valid  <= s0_valid;
            if (adv2) out_valid <= s1_valid;
            if (adv2 && s1_valid) begin
                out     <= s1_sum + s1_car;
                out_tag <= s1_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv0 && in_valid) begin
            s0_a   <= a;
            s0_b   <= b;
            s0_tag <= in_tag;
            s0_tc  <= tc_in;
        end
        if (adv1 && s0_valid) begin
            s1_sum <= red_sum;
            s1_car <= red_car;
            s1_tag <= s0_tag;
        end
    end

endmodule
